// File: rtl/droute_sched_if.sv
// Control bundle between host/config logic, data_route handshake monitors and droute_sched.
// slave = scheduler side, master = host/integrator side.
interface droute_sched_if #(
    parameter int AW     = 3,
    parameter int BEAT_W = 16,
    parameter int SW_W   = 36,
    parameter int MON_N  = 8
);
    logic              cfg_wr_en;
    logic [AW-1:0]     cfg_wr_addr;
    logic [SW_W-1:0]   cfg_wr_sw0;
    logic [SW_W-1:0]   cfg_wr_sw1;
    logic [BEAT_W-1:0] cfg_wr_beats;
    logic [2:0]        cfg_wr_mon;
    logic [AW-1:0]     cfg_last;
    logic              start;
    logic              abort;
    logic [MON_N-1:0]  mon_hs;
    logic [SW_W-1:0]   droute_switch_0;
    logic [SW_W-1:0]   droute_switch_1;
    logic              gate;
    logic              busy;
    logic              done;
    logic [AW-1:0]     cur_entry;
    logic              err;

    modport slave (
        input  cfg_wr_en, cfg_wr_addr, cfg_wr_sw0, cfg_wr_sw1, cfg_wr_beats, cfg_wr_mon,
        input  cfg_last, start, abort, mon_hs,
        output droute_switch_0, droute_switch_1, gate, busy, done, cur_entry, err
    );

    modport master (
        output cfg_wr_en, cfg_wr_addr, cfg_wr_sw0, cfg_wr_sw1, cfg_wr_beats, cfg_wr_mon,
        output cfg_last, start, abort, mon_hs,
        input  droute_switch_0, droute_switch_1, gate, busy, done, cur_entry, err
    );
endinterface

// File: rtl/droute_sched.sv
// Phase sequencer for data_route: per table entry sets switch words, opens gate for N beats, drains; DROUTE_SCHED_LOOP_EN repeats the table.
// Latency: switch words valid the cycle after APPLY, gate one cycle later; done DRAIN_CYC quiet cycles after the last beat.
// Backpressure: no stalls of its own; beats are counted only on completed mon_hs handshakes, so a stalled output just lengthens RUN.
module droute_sched #(
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int BEAT_W    = 16,
    parameter int SW_W      = 36,
    parameter int MON_N     = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    droute_sched_if.slave bus
);
    localparam int QW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [2:0] {IDLE, APPLY, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [SW_W-1:0]   sw0;
        logic [SW_W-1:0]   sw1;
        logic [BEAT_W-1:0] beats;
        logic [2:0]        mon;
    } entry_t;

    entry_t            table_q [DEPTH];
    entry_t            ent;
    logic [MON_N-1:0]  hs;
    logic              hs_sel;

    state_t            state_q, state_d;
    logic [SW_W-1:0]   sw0_q, sw0_d, sw1_q, sw1_d;
    logic [BEAT_W-1:0] beats_q, beats_d, cnt_q, cnt_d;
    logic [2:0]        mon_q, mon_d;
    logic [QW-1:0]     quiet_q, quiet_d;
    logic [AW-1:0]     cur_q, cur_d, last_q, last_d;
    logic              gate_q, gate_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              aborting_q, aborting_d;

    assign ent    = table_q[cur_q];
    assign hs     = bus.mon_hs;
    assign hs_sel = hs[mon_q];

    // Writes while a sequence runs are dropped so the active table never changes under it.
    always_ff @(posedge clk) begin
        if (bus.cfg_wr_en && !busy_q)
            table_q[bus.cfg_wr_addr] <= {bus.cfg_wr_sw0, bus.cfg_wr_sw1, bus.cfg_wr_beats, bus.cfg_wr_mon};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sw0_q      <= '0;
            sw1_q      <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            mon_q      <= '0;
            quiet_q    <= '0;
            cur_q      <= '0;
            last_q     <= '0;
            gate_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            aborting_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sw0_q      <= sw0_d;
            sw1_q      <= sw1_d;
            beats_q    <= beats_d;
            cnt_q      <= cnt_d;
            mon_q      <= mon_d;
            quiet_q    <= quiet_d;
            cur_q      <= cur_d;
            last_q     <= last_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            aborting_q <= aborting_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sw0_d      = sw0_q;
        sw1_d      = sw1_q;
        beats_d    = beats_q;
        cnt_d      = cnt_q;
        mon_d      = mon_q;
        quiet_d    = quiet_q;
        cur_d      = cur_q;
        last_d     = last_q;
        gate_d     = gate_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        aborting_d = aborting_q;

        if (busy_q && (bus.start || bus.cfg_wr_en))
            err_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    last_d     = bus.cfg_last;
                    cur_d      = '0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    aborting_d = 1'b0;
                    state_d    = APPLY;
                end
            end
            APPLY: begin
                sw0_d   = ent.sw0;
                sw1_d   = ent.sw1;
                beats_d = ent.beats;
                mon_d   = ent.mon;
                cnt_d   = '0;
                quiet_d = '0;
                state_d = (ent.beats != '0) ? RUN : DRAIN;
            end
            RUN: begin
                // First RUN cycle keeps the gate shut so the new switch words settle for a full cycle.
                if (!gate_q) begin
                    gate_d = 1'b1;
                end else if (hs_sel) begin
                    if (cnt_q == beats_q - BEAT_W'(1)) begin
                        gate_d  = 1'b0;
                        quiet_d = '0;
                        state_d = DRAIN;
                    end
                    if (cnt_q != {BEAT_W{1'b1}})
                        cnt_d = cnt_q + BEAT_W'(1);
                end
            end
            DRAIN: begin
                if (|hs) begin
                    quiet_d = '0;
                end else if (quiet_q == QW'(DRAIN_CYC - 1)) begin
                    if (aborting_q) begin
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end else if (cur_q == last_q) begin
                        done_d = 1'b1;
`ifdef DROUTE_SCHED_LOOP_EN
                        cur_d   = '0;
                        state_d = APPLY;
`else
                        busy_d  = 1'b0;
                        state_d = DONE;
`endif
                    end else begin
                        cur_d   = cur_q + AW'(1);
                        state_d = APPLY;
                    end
                end else begin
                    quiet_d = quiet_q + QW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Abort overrides everything above, including a final beat or drain completion in the same cycle.
        if (bus.abort && (state_q == APPLY || state_q == RUN || state_q == DRAIN)) begin
            gate_d     = 1'b0;
            quiet_d    = '0;
            aborting_d = 1'b1;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            cur_d      = cur_q;
            state_d    = DRAIN;
        end
    end

    assign bus.droute_switch_0 = sw0_q;
    assign bus.droute_switch_1 = sw1_q;
    assign bus.gate            = gate_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cur_entry       = cur_q;
    assign bus.err             = err_q;
endmodule

// File: tb/tb_droute_sched.sv
// Bench for droute_sched: single-phase vector table, scoreboard of applied phases (entry + switch words),
// hand sequences for multi-entry, drain hold-off, abort, busy errors, loop mode and async reset.
`timescale 1ns/1ps
module tb_droute_sched;
    localparam int DRAIN_CYC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    droute_sched_if bus ();
    droute_sched dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct { logic [2:0] e; logic [35:0] s0; logic [35:0] s1; } sb_t;
    sb_t sb[$];

    logic [35:0] m_sw0 [8];
    logic [35:0] m_sw1 [8];

    logic [2:0] sel_ch = 3'd0;
    logic       follow = 1'b1;
    logic       burst  = 1'b0;
    int         pulse_left = 0;

    int   cyc = 0, beats_seen = 0, gate_cyc = 0, done_cnt = 0, done_cyc = 0, gate_fall_cyc = 0, last_p2 = 0;
    logic busy_at_done = 1'b0;
    int   gate_e [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Traffic model: selected output transfers only while gated, plus noise on a neighbour and optional drain pulses on output c.
    initial begin
        logic [7:0] v;
        bus.mon_hs = '0;
        forever begin
            @(posedge clk);
            #1;
            v = '0;
            if (follow && bus.gate) begin
                v[sel_ch]        = burst ? 1'($urandom_range(0, 1)) : 1'b1;
                v[sel_ch ^ 3'd1] = 1'($urandom_range(0, 1));
            end
            if (pulse_left > 0) begin
                if (pulse_left % 3 == 0) v[2] = 1'b1;
                pulse_left--;
            end
            bus.mon_hs = v;
        end
    end

    // Monitor + scoreboard: a phase starts when busy rises or cur_entry moves; its switch words show one cycle later.
    initial begin
        sb_t        it;
        logic       pend = 1'b0, prev_busy = 1'b0, prev_gate = 1'b0;
        logic [2:0] prev_cur = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.gate) begin
                gate_cyc++;
                gate_e[bus.cur_entry]++;
                if (bus.mon_hs[sel_ch]) beats_seen++;
            end
            if (prev_gate && !bus.gate) gate_fall_cyc = cyc;
            if (bus.mon_hs[2]) last_p2 = cyc;
            if (bus.done) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = bus.busy;
            end
            if (pend) begin
                chk("sb_pending", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    it = sb.pop_front();
                    chk("sb_entry", bus.cur_entry, it.e);
                    chk("sb_sw0", bus.droute_switch_0, it.s0);
                    chk("sb_sw1", bus.droute_switch_1, it.s1);
                end
            end
            pend      = bus.busy && (!prev_busy || bus.cur_entry != prev_cur);
            prev_busy = bus.busy;
            prev_cur  = bus.cur_entry;
            prev_gate = bus.gate;
        end
    end

    task automatic cfg_write(input logic [2:0] a, input logic [35:0] s0, input logic [35:0] s1,
                             input logic [15:0] b, input logic [2:0] m, input logic taken);
        @(posedge clk);
        #1;
        bus.cfg_wr_en    = 1'b1;
        bus.cfg_wr_addr  = a;
        bus.cfg_wr_sw0   = s0;
        bus.cfg_wr_sw1   = s1;
        bus.cfg_wr_beats = b;
        bus.cfg_wr_mon   = m;
        @(posedge clk);
        #1;
        bus.cfg_wr_en = 1'b0;
        if (taken) begin
            m_sw0[a] = s0;
            m_sw1[a] = s1;
        end
    endtask

    task automatic push_phase(input int e);
        sb.push_back('{3'(e), m_sw0[e], m_sw1[e]});
    endtask

    task automatic do_start(input logic [2:0] last, input logic push);
        bus.cfg_last = last;
        if (push) for (int i = 0; i <= int'(last); i++) push_phase(i);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic clr_stats();
        beats_seen = 0; gate_cyc = 0; done_cnt = 0; done_cyc = 0;
        gate_fall_cyc = 0; last_p2 = 0; busy_at_done = 1'b0;
        for (int i = 0; i < 8; i++) gate_e[i] = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (bus.busy && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(nm, bus.busy, 1'b0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [35:0] s0;
        logic [35:0] s1;
        logic [15:0] beats;
        logic [2:0]  mon;
        logic        burst;
        int          exp_beats;
        int          exp_gate;   // -1: gate-high cycles depend on random bursts
    } vec_t;

    initial begin
        vec_t vt [5];
        int   n;
        vt[0] = '{36'h1_0099,      36'h8048,        16'd10, 3'd0, 1'b0, 10, 10};
        vt[1] = '{36'hF_FFFF_FFFF, 36'h0,           16'd1,  3'd7, 1'b0, 1,  1};
        vt[2] = '{36'h1_2345_6789, 36'hA_BCDE_F012, 16'd0,  3'd3, 1'b0, 0,  0};
        vt[3] = '{36'h5,           36'hA,           16'd6,  3'd4, 1'b1, 6,  -1};
        vt[4] = '{36'h1,           36'h8_0000_0000, 16'd3,  3'd2, 1'b0, 3,  3};

        rst_n = 1'b0;
        bus.cfg_wr_en = 1'b0; bus.cfg_wr_addr = '0; bus.cfg_wr_sw0 = '0; bus.cfg_wr_sw1 = '0;
        bus.cfg_wr_beats = '0; bus.cfg_wr_mon = '0; bus.cfg_last = '0;
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sw0", bus.droute_switch_0, 36'h0);
        chk("rst_sw1", bus.droute_switch_1, 36'h0);
        chk("rst_gate", bus.gate, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_cur", bus.cur_entry, 3'd0);
        chk("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;

`ifndef DROUTE_SCHED_LOOP_EN
        for (int i = 0; i < 5; i++) begin
            cfg_write(3'd0, vt[i].s0, vt[i].s1, vt[i].beats, vt[i].mon, 1'b1);
            sel_ch = vt[i].mon;
            burst  = vt[i].burst;
            clr_stats();
            do_start(3'd0, 1'b1);
            wait_idle($sformatf("v%0d_timeout", i));
            chk($sformatf("v%0d_beats", i), beats_seen, vt[i].exp_beats);
            if (vt[i].exp_gate >= 0) chk($sformatf("v%0d_gate_cyc", i), gate_cyc, vt[i].exp_gate);
            chk($sformatf("v%0d_done_cnt", i), done_cnt, 1);
            chk($sformatf("v%0d_busy_at_done", i), busy_at_done, 1'b0);
            if (vt[i].beats != 0) chk($sformatf("v%0d_drain_lat", i), done_cyc - gate_fall_cyc, DRAIN_CYC);
            chk($sformatf("v%0d_sw0_hold", i), bus.droute_switch_0, vt[i].s0);
            chk($sformatf("v%0d_sw1_hold", i), bus.droute_switch_1, vt[i].s1);
            chk($sformatf("v%0d_err", i), bus.err, 1'b0);
        end

        // Three entries, middle one skipped, bursty traffic on output e.
        cfg_write(3'd0, 36'h111, 36'h222, 16'd3, 3'd4, 1'b1);
        cfg_write(3'd1, 36'h333, 36'h444, 16'd0, 3'd4, 1'b1);
        cfg_write(3'd2, 36'h555, 36'h666, 16'd5, 3'd4, 1'b1);
        sel_ch = 3'd4; burst = 1'b1; clr_stats();
        do_start(3'd2, 1'b1);
        wait_idle("t2_timeout");
        chk("t2_beats", beats_seen, 8);
        chk("t2_done_cnt", done_cnt, 1);
        chk("t2_gate_entry1", gate_e[1], 0);
        chk("t2_cur_hold", bus.cur_entry, 3'd2);

        // Drain hold-off: handshakes on c every 3 cycles keep the scheduler in DRAIN.
        cfg_write(3'd0, 36'hAAA, 36'hBBB, 16'd2, 3'd0, 1'b1);
        sel_ch = 3'd0; burst = 1'b0; clr_stats();
        do_start(3'd0, 1'b1);
        n = 0;
        while (!bus.gate && n < 50) begin @(negedge clk); #1; n++; end
        while (bus.gate && n < 100) begin @(negedge clk); #1; n++; end
        pulse_left = 12;
        repeat (8) @(negedge clk);
        #1;
        chk("t3_hold_busy", bus.busy, 1'b1);
        chk("t3_hold_gate", bus.gate, 1'b0);
        chk("t3_hold_done", done_cnt, 0);
        wait_idle("t3_timeout");
        chk("t3_quiet_lat", done_cyc - last_p2, DRAIN_CYC + 1);
        chk("t3_gate_cyc", gate_cyc, 2);

        // Abort at beat 5 of 10.
        cfg_write(3'd0, 36'hC0C0, 36'h0C0C, 16'd10, 3'd0, 1'b1);
        clr_stats();
        do_start(3'd0, 1'b1);
        n = 0;
        while (beats_seen < 5 && n < 100) begin @(negedge clk); #1; n++; end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        chk("t4_gate_off", bus.gate, 1'b0);
        wait_idle("t4_timeout");
        chk("t4_beats", beats_seen, 5);
        chk("t4_gate_cyc", gate_cyc, 5);
        chk("t4_no_done", done_cnt, 0);

        // Start and write while busy: error flagged, table untouched, next idle start clears err.
        cfg_write(3'd0, 36'h777, 36'h888, 16'd20, 3'd0, 1'b1);
        clr_stats();
        do_start(3'd0, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        cfg_write(3'd0, 36'hD_EAD0, 36'hB_EEF0, 16'd1, 3'd1, 1'b0);
        chk("t5_err_wr", bus.err, 1'b1);
        do_start(3'd0, 1'b0);
        chk("t5_busy", bus.busy, 1'b1);
        wait_idle("t5_timeout");
        chk("t5_err_sticky", bus.err, 1'b1);
        chk("t5_beats", beats_seen, 20);
        clr_stats();
        do_start(3'd0, 1'b1);
        chk("t5_err_clr", bus.err, 1'b0);
        wait_idle("t5b_timeout");
        chk("t5_table_kept", beats_seen, 20);
`else
        // Loop mode: 0,1,0,1,... with a done per pass until abort.
        cfg_write(3'd0, 36'h101, 36'h202, 16'd2, 3'd0, 1'b1);
        cfg_write(3'd1, 36'h303, 36'h404, 16'd3, 3'd0, 1'b1);
        sel_ch = 3'd0; burst = 1'b0; clr_stats();
        do_start(3'd1, 1'b1);
        push_phase(0); push_phase(1); push_phase(0);
        n = 0;
        while (done_cnt < 2 && n < 500) begin @(negedge clk); #1; n++; end
        chk("l_two_passes", done_cnt, 2);
        chk("l_busy_at_done", busy_at_done, 1'b1);
        n = 0;
        while (!(bus.gate && bus.cur_entry == 3'd0) && n < 100) begin @(negedge clk); #1; n++; end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        wait_idle("l_timeout");
        chk("l_done_cnt", done_cnt, 2);
        chk("l_beats", beats_seen, 11);
        chk("l_sb_empty", sb.size(), 0);
`endif

        // Async reset in the middle of entry 1's RUN.
        cfg_write(3'd0, 36'h1, 36'h2, 16'd1, 3'd0, 1'b1);
        cfg_write(3'd1, 36'hF_0F0F_0F0F, 36'h0_F0F0_F0F0, 16'd50, 3'd0, 1'b1);
        sel_ch = 3'd0; burst = 1'b0; clr_stats();
        do_start(3'd1, 1'b1);
        n = 0;
        while (!(bus.gate && bus.cur_entry == 3'd1) && n < 100) begin @(negedge clk); #1; n++; end
        chk("r_reached_run", bus.gate, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("r_sw0", bus.droute_switch_0, 36'h0);
        chk("r_sw1", bus.droute_switch_1, 36'h0);
        chk("r_gate", bus.gate, 1'b0);
        chk("r_busy", bus.busy, 1'b0);
        chk("r_done", bus.done, 1'b0);
        chk("r_cur", bus.cur_entry, 3'd0);
        chk("r_err", bus.err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
